sipo_frame_rx: RTL and testbench

- Serial-to-parallel receiver that consumes the LSB-first serial stream produced by the team's 4-bit PISO shift register.
- Collects WIDTH bits on strobe and presents each completed word on a one-entry valid/ready output buffer.
- Sticky overrun flag reports words lost while the buffer is full.
- Sits directly downstream of the PISO: `sin` is driven by PISO `sout`, and `sin_en` is driven by the PISO's `shift_right` strobe.

---
 rtl/sipo_frame_rx_if.sv | 28 ++
 rtl/sipo_frame_rx.sv | 114 +++++++++++
 tb/tb_sipo_frame_rx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_frame_rx_if.sv
// Interface for the sipo_frame_rx block. It carries the serial input, the framing controls
// and the valid/ready parallel word output.
interface sipo_frame_rx_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             sin;
    logic             sin_en;
    logic             frame_start;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic             busy;
    logic [CW-1:0]    bit_cnt;
    logic             overrun;
    logic             ovr_clr;

    modport master (
        output sin, sin_en, frame_start, pout_ready, ovr_clr,
        input  pout, pout_valid, busy, bit_cnt, overrun
    );

    modport slave (
        input  sin, sin_en, frame_start, pout_ready, ovr_clr,
        output pout, pout_valid, busy, bit_cnt, overrun
    );
endinterface

// File: rtl/sipo_frame_rx.sv
// LSB-first serial-to-parallel frame receiver with a one-entry valid/ready output buffer.
// A sticky overrun flag is set whenever a completed word arrives while that buffer is still full.
module sipo_frame_rx #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input logic          clk,
    input logic          rst,
    sipo_frame_rx_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_e;

    state_e           state_q, state_d;
    state_e           cur_state;
    logic [CW-1:0]    cnt_q, cnt_d, cur_cnt;
    // The register keeps only the upper WIDTH-1 bits. The newest bit comes straight from sin
    // when a word completes.
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic [WIDTH-1:0] word;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             complete;

    // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            pout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        pout_d    = pout_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
        word      = {bus.sin, sr_q};
        complete  = 1'b0;
        cur_state = state_q;
        cur_cnt   = cnt_q;

        // Realign first, so that a coincident strobe starts the new frame.
        if (bus.frame_start) begin
            cur_state = IDLE;
            cur_cnt   = '0;
            state_d   = IDLE;
            cnt_d     = '0;
        end

        if (bus.sin_en) begin
            sr_d = word[WIDTH-1:1];
            case (cur_state)
                IDLE: begin
                    state_d = RECV;
                    cnt_d   = CW'(1);
                end
                RECV: begin
                    if (cur_cnt == CW'(WIDTH - 1)) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cur_cnt + CW'(1);
                    end
                end
            endcase
        end

        if (valid_q && bus.pout_ready) begin
            valid_d = 1'b0;
        end

        if (bus.ovr_clr) begin
            ovr_d = 1'b0;
        end

        // A word that completes into a full, stalled buffer is dropped. In that case the set
        // overrides a same-cycle clear.
        if (complete) begin
            if (!valid_q || bus.pout_ready) begin
                pout_d  = word;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign bus.pout       = pout_q;
    assign bus.pout_valid = valid_q;
    assign bus.bit_cnt    = cnt_q;
    assign bus.busy       = (cnt_q != '0);
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx. A bit-list reference model is compared against the DUT
// on every cycle, and directed scenarios pin key values by hand.
module tb_sipo_frame_rx;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic clk;
    logic rst;

    sipo_frame_rx_if #(.WIDTH(W)) bus ();

    sipo_frame_rx #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: bits of the current frame are kept as an integer accumulator.
    int          m_nbits;
    logic [31:0] m_acc;
    logic [W-1:0] m_pout;
    logic        m_valid;
    logic        m_ovr;
    logic [W-1:0] m_word;
    logic        m_done;
    logic        m_nv;
    logic        m_set;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_nbits = 0;
            m_acc   = '0;
            m_pout  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            m_done = 1'b0;
            m_set  = 1'b0;
            m_word = '0;
            if (bus.frame_start) begin
                m_nbits = 0;
                m_acc   = '0;
            end
            if (bus.sin_en) begin
                m_acc[m_nbits] = bus.sin;
                m_nbits++;
                if (m_nbits == W) begin
                    m_done  = 1'b1;
                    m_word  = m_acc[W-1:0];
                    m_nbits = 0;
                    m_acc   = '0;
                end
            end
            m_nv = m_valid && !bus.pout_ready;
            if (m_done) begin
                if (!m_valid || bus.pout_ready) begin
                    m_pout = m_word;
                    m_nv   = 1'b1;
                end else begin
                    m_set = 1'b1;
                end
            end
            m_valid = m_nv;
            m_ovr   = (bus.ovr_clr ? 1'b0 : m_ovr) | m_set;
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        vectors++;
        if (bus.pout !== m_pout || bus.pout_valid !== m_valid || bus.overrun !== m_ovr ||
            bus.bit_cnt !== CW'(m_nbits) || bus.busy !== (m_nbits != 0)) begin
            miscompares++;
            $display("FAIL model t=%0t: got pout=%h v=%b ovr=%b cnt=%0d busy=%b, want pout=%h v=%b ovr=%b cnt=%0d busy=%b",
                     $time, bus.pout, bus.pout_valid, bus.overrun, bus.bit_cnt, bus.busy,
                     m_pout, m_valid, m_ovr, m_nbits, (m_nbits != 0));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic en, input logic fs, input logic rdy, input logic clr);
        @(negedge clk);
        #1;
        bus.sin         = s;
        bus.sin_en      = en;
        bus.frame_start = fs;
        bus.pout_ready  = rdy;
        bus.ovr_clr     = clr;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    // Emulates a PISO that is loaded with w and shifts right, one bit per cycle.
    task automatic piso_send(input logic [W-1:0] w, input logic rdy, input logic rdy_last, input logic clr_last);
        logic [W-1:0] piso;
        piso = w;
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) drive(piso[0], 1'b1, 1'b0, rdy_last, clr_last);
            else            drive(piso[0], 1'b1, 1'b0, rdy, 1'b0);
            piso = piso >> 1;
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.sin         = 1'b0;
        bus.sin_en      = 1'b0;
        bus.frame_start = 1'b0;
        bus.pout_ready  = 1'b0;
        bus.ovr_clr     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_pout", 32'(bus.pout), 32'h0);
        check("reset_valid", 32'(bus.pout_valid), 32'h0);
        #1 rst = 1'b0;

        // Bits 1,0,1,1 received LSB first form 4'hD.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        check("t1_pout", 32'(bus.pout), 32'hD);
        check("t1_valid", 32'(bus.pout_valid), 32'h1);
        check("t1_busy", 32'(bus.busy), 32'h0);
        check("t1_cnt", 32'(bus.bit_cnt), 32'h0);
        idle(1'b1);
        check("t1_valid_drop", 32'(bus.pout_valid), 32'h0);

        // Back-to-back PISO loopback.
        piso_send(4'hA, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("loop_a", 32'(bus.pout), 32'hA);
        piso_send(4'h5, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("loop_5", 32'(bus.pout), 32'h5);

        // Overrun while stalled.
        piso_send(4'h3, 1'b0, 1'b0, 1'b0);
        piso_send(4'hC, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("ovr_pout", 32'(bus.pout), 32'h3);
        check("ovr_flag", 32'(bus.overrun), 32'h1);
        check("ovr_valid", 32'(bus.pout_valid), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        check("ovr_clr", 32'(bus.overrun), 32'h0);
        idle(1'b0);
        check("ovr_drain", 32'(bus.pout_valid), 32'h0);

        // Realign after two bits. The frame_start bit becomes bit 0 of the new frame.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        check("realign_cnt2", 32'(bus.bit_cnt), 32'h2);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        check("realign_pout", 32'(bus.pout), 32'h7);

        // A completion coincides with the handshake of the previous word.
        idle(1'b1);
        piso_send(4'h9, 1'b0, 1'b0, 1'b0);
        piso_send(4'h6, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        check("simul_pout", 32'(bus.pout), 32'h6);
        check("simul_valid", 32'(bus.pout_valid), 32'h1);
        check("simul_ovr", 32'(bus.overrun), 32'h0);

        // When ovr_clr coincides with a new overrun, the set wins.
        piso_send(4'h2, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        check("clr_vs_set", 32'(bus.overrun), 32'h1);
        check("clr_vs_set_pout", 32'(bus.pout), 32'h6);

        // Asynchronous reset mid-frame with a word pending.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        check("pre_rst_cnt", 32'(bus.bit_cnt), 32'h3);
        #2 rst = 1'b1;
        #1;
        check("arst_pout", 32'(bus.pout), 32'h0);
        check("arst_valid", 32'(bus.pout_valid), 32'h0);
        check("arst_cnt", 32'(bus.bit_cnt), 32'h0);
        check("arst_busy", 32'(bus.busy), 32'h0);
        check("arst_ovr", 32'(bus.overrun), 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        piso_send(4'hB, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("post_rst_pout", 32'(bus.pout), 32'hB);

        // Random traffic, checked against the model on every cycle.
        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 19) == 0));
        end
        idle(1'b1);
        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
